// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, condition codes and sequencer states for the branch controller
package cpu_pkg;

    localparam logic [2:0] OP_BRR     = 3'b101;
    localparam logic [2:0] OP_BRA     = 3'b111;
    localparam logic [2:0] OP_CMP     = 3'b110;
    localparam logic [8:0] HALT_INSTR = 9'b100_111111;

    typedef enum logic [1:0] {
        C_NEVER = 2'b00,
        C_EQ    = 2'b01,
        C_LT    = 2'b10,
        C_GT    = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - absolute branch target table, one write port and one asynchronous read port
module branch_lut #(
    parameter int PC_WIDTH  = 12,
    parameter int LUT_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [3:0]          waddr,
    input  logic [PC_WIDTH-1:0] wdata,
    input  logic [3:0]          raddr,
    output logic [PC_WIDTH-1:0] rdata
);

    logic [PC_WIDTH-1:0] mem [LUT_DEPTH];

    // Table storage; reset clears every entry and takes priority over a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write to this index returns the old value.
    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/CMP/HALT decoder, flag register and program sequencer feeding the PC
module branch_ctrl #(
    parameter int PC_WIDTH  = 12,
    parameter int INSTR_W   = 9,
    parameter int DATA_W    = 8,
    parameter int LUT_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [DATA_W-1:0]   cmp_a,
    input  logic [DATA_W-1:0]   cmp_b,
    input  logic                lut_we,
    input  logic [3:0]          lut_waddr,
    input  logic [PC_WIDTH-1:0] lut_wdata,
    output logic                pc_hold,
    output logic                EQ,
    output logic                LT,
    output logic                GT,
    output logic [1:0]          cond_sel,
    output logic                abs_branch_en,
    output logic                rel_branch_en,
    output logic [3:0]          rel_branch_offset,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic [15:0]         run_cycles
);

    import cpu_pkg::*;

    seq_state_e state;
    seq_state_e state_next;
    logic       resume_skip;
    logic [2:0] opcode;
    logic       is_brr;
    logic       is_bra;
    logic       is_cmp;
    logic       is_halt;
    logic       in_run;
    logic       run_release;
    cond_e      cond;

    assign opcode      = instr[8:6];
    assign is_brr      = (opcode == OP_BRR);
    assign is_bra      = (opcode == OP_BRA);
    assign is_cmp      = (opcode == OP_CMP);
    assign is_halt     = (instr == HALT_INSTR);
    assign in_run      = (state == RUN);
    assign run_release = (state == ARMED) && !start;

    branch_lut #(
        .PC_WIDTH  (PC_WIDTH),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (instr[3:0]),
        .rdata (next_pc)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and PC hold: the PC only advances while running, except the one
    // step past HALT taken at the start-release edge when resuming a program.
    always_comb begin
        state_next = state;
        pc_hold    = 1'b0;
        case (state)
            IDLE: begin
                pc_hold = 1'b1;
                if (start) state_next = ARMED;
            end
            ARMED: begin
                pc_hold = start | ~resume_skip;
                if (!start) state_next = RUN;
            end
            RUN: begin
                pc_hold = is_halt;
                if (is_halt) state_next = DONE;
            end
            DONE: begin
                pc_hold = 1'b1;
                if (start) state_next = ARMED;
            end
            default: begin
                pc_hold    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Branch request decode; a branch only reaches the PC while running.
    always_comb begin
        cond          = C_NEVER;
        abs_branch_en = 1'b0;
        rel_branch_en = 1'b0;
        if (in_run && (is_brr || is_bra)) begin
            cond          = cond_e'(instr[5:4]);
            abs_branch_en = is_bra;
            rel_branch_en = is_brr;
        end
    end

    assign cond_sel          = cond;
    assign rel_branch_offset = instr[3:0];

    // Compare flags: updated one edge after a CMP, so a same-cycle branch uses the previous result.
    always_ff @(posedge clk) begin
        if (reset) begin
            EQ <= 1'b0;
            LT <= 1'b0;
            GT <= 1'b0;
        end else if (in_run && is_cmp) begin
            EQ <= (cmp_a == cmp_b);
            LT <= (cmp_a <  cmp_b);
            GT <= (cmp_a >  cmp_b);
        end
    end

    // Per-program run length, restarted when the program is released and saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles <= '0;
        end else if (run_release) begin
            run_cycles <= '0;
        end else if (in_run && run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
        end
    end

    // Halt handshake: done rises with the entry into DONE and drops once start is seen;
    // resume_skip remembers that the PC is parked on a HALT and must step over it on resume.
    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            resume_skip <= 1'b0;
        end else begin
            if (in_run && is_halt) begin
                done        <= 1'b1;
                resume_skip <= 1'b1;
            end else begin
                if (state == DONE && start) done <= 1'b0;
                if (run_release) resume_skip <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl against a behavioural program model
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [8:0]  instr;
    logic [7:0]  cmp_a;
    logic [7:0]  cmp_b;
    logic        lut_we;
    logic [3:0]  lut_waddr;
    logic [11:0] lut_wdata;
    logic        pc_hold;
    logic        EQ;
    logic        LT;
    logic        GT;
    logic [1:0]  cond_sel;
    logic        abs_branch_en;
    logic        rel_branch_en;
    logic [3:0]  rel_branch_offset;
    logic [11:0] next_pc;
    logic [15:0] run_cycles;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .done              (done),
        .instr             (instr),
        .cmp_a             (cmp_a),
        .cmp_b             (cmp_b),
        .lut_we            (lut_we),
        .lut_waddr         (lut_waddr),
        .lut_wdata         (lut_wdata),
        .pc_hold           (pc_hold),
        .EQ                (EQ),
        .LT                (LT),
        .GT                (GT),
        .cond_sel          (cond_sel),
        .abs_branch_en     (abs_branch_en),
        .rel_branch_en     (rel_branch_en),
        .rel_branch_offset (rel_branch_offset),
        .next_pc           (next_pc),
        .run_cycles        (run_cycles)
    );

    // Program model: where the program is in its life, plus the architectural state.
    bit          m_armed;
    bit          m_running;
    bit          m_halted;
    bit          m_skip;
    bit          m_done;
    bit          m_eq;
    bit          m_lt;
    bit          m_gt;
    int          m_cycles;
    logic [11:0] m_lut [16];
    bit          model_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] NOP  = 9'h000;
    localparam logic [8:0] HALT = 9'b100_111111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit       idle;
        bit       is_halt;
        bit       is_branch;
        bit [2:0] op;
        bit       exp_hold;
        op        = instr[8:6];
        is_halt   = (instr == HALT);
        is_branch = (op == 3'b101) || (op == 3'b111);
        idle      = !(m_armed || m_running || m_halted);
        exp_hold  = idle || m_halted || (m_running && is_halt) || (m_armed && (start || !m_skip));
        chk("pc_hold", pc_hold, exp_hold);
        chk("done", done, m_done);
        chk("EQ", EQ, m_eq);
        chk("LT", LT, m_lt);
        chk("GT", GT, m_gt);
        chk("run_cycles", run_cycles, m_cycles);
        chk("cond_sel", cond_sel, (m_running && is_branch) ? instr[5:4] : 2'b00);
        chk("abs_branch_en", abs_branch_en, m_running && op == 3'b111);
        chk("rel_branch_en", rel_branch_en, m_running && op == 3'b101);
        chk("rel_branch_offset", rel_branch_offset, instr[3:0]);
        chk("next_pc", next_pc, m_lut[instr[3:0]]);
    endtask

    task automatic model_update();
        bit was_idle;
        bit was_armed;
        bit was_run;
        bit was_halted;
        bit is_halt;
        if (reset) begin
            m_armed = 0; m_running = 0; m_halted = 0;
            m_skip = 0; m_done = 0; m_cycles = 0;
            m_eq = 0; m_lt = 0; m_gt = 0;
            for (int i = 0; i < 16; i++) m_lut[i] = 12'h000;
            return;
        end
        was_armed  = m_armed;
        was_run    = m_running;
        was_halted = m_halted;
        was_idle   = !(m_armed || m_running || m_halted);
        is_halt    = (instr == HALT);
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
        if (was_run && instr[8:6] == 3'b110) begin
            m_eq = (cmp_a == cmp_b);
            m_lt = (cmp_a < cmp_b);
            m_gt = (cmp_a > cmp_b);
        end
        if (was_run) m_cycles = (m_cycles >= 65535) ? 65535 : m_cycles + 1;
        if (was_run && is_halt) m_done = 1;
        else if (was_halted && start) m_done = 0;
        if (was_idle && start) m_armed = 1;
        if (was_armed && !start) begin
            m_armed = 0; m_running = 1; m_cycles = 0; m_skip = 0;
        end
        if (was_run && is_halt) begin
            m_running = 0; m_halted = 1; m_skip = 1;
        end
        if (was_halted && start) begin
            m_halted = 0; m_armed = 1;
        end
    endtask

    task automatic apply(input logic rst, input logic st, input logic [8:0] ins,
                         input logic [7:0] a, input logic [7:0] b, input logic we,
                         input logic [3:0] wa, input logic [11:0] wd);
        @(negedge clk);
        reset = rst; start = st; instr = ins; cmp_a = a; cmp_b = b;
        lut_we = we; lut_waddr = wa; lut_wdata = wd;
        #1;
        if (model_valid) compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        if (reset) model_valid = 1'b1;
    endtask

    task automatic step(input logic st, input logic [8:0] ins, input logic [7:0] a, input logic [7:0] b);
        apply(1'b0, st, ins, a, b, 1'b0, 4'h0, 12'h000);
    endtask

    initial begin
        int          start_cnt;
        logic        st;
        logic        rst;
        logic [8:0]  ins;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        we;

        reset = 1; start = 0; instr = NOP; cmp_a = 0; cmp_b = 0;
        lut_we = 0; lut_waddr = 0; lut_wdata = 0;

        // Reset, then start held three cycles and released.
        apply(1'b1, 1'b0, NOP, 8'd0, 8'd0, 1'b0, 4'h0, 12'h000); tick();
        step(1, NOP, 0, 0);
        chk("t1_idle_hold", pc_hold, 1'b1);
        chk("t1_reset_done", done, 1'b0);
        chk("t1_reset_flags", {EQ, LT, GT}, 3'b000);
        tick();
        step(1, NOP, 0, 0); chk("t1_armed_hold", pc_hold, 1'b1); tick();
        step(1, NOP, 0, 0); tick();
        step(0, NOP, 0, 0); chk("t1_release_hold", pc_hold, 1'b1); tick();
        step(0, NOP, 0, 0); chk("t1_run_hold", pc_hold, 1'b0); chk("t1_rc0", run_cycles, 16'd0); tick();
        step(0, NOP, 0, 0); chk("t1_rc1", run_cycles, 16'd1); tick();
        step(0, NOP, 0, 0); chk("t1_rc2", run_cycles, 16'd2); tick();

        // CMP 5 vs 9, then BRR LT -2.
        step(0, 9'b110_000000, 8'd5, 8'd9); chk("t2_lt_before", LT, 1'b0); tick();
        step(0, 9'b101_10_1110, 0, 0);
        chk("t2_lt", LT, 1'b1);
        chk("t2_cond", cond_sel, 2'b10);
        chk("t2_rel_en", rel_branch_en, 1'b1);
        chk("t2_off", rel_branch_offset, 4'hE);
        tick();

        // Absolute branch through lut[3], including a same-cycle write returning the old entry.
        apply(1'b0, 1'b0, NOP, 8'd0, 8'd0, 1'b1, 4'h3, 12'h0A0); tick();
        step(0, 9'b110_000000, 8'd7, 8'd7); tick();
        step(0, 9'b111_01_0011, 0, 0);
        chk("t3_next_pc", next_pc, 12'h0A0);
        chk("t3_abs_en", abs_branch_en, 1'b1);
        chk("t3_cond", cond_sel, 2'b01);
        chk("t3_eq", EQ, 1'b1);
        tick();
        apply(1'b0, 1'b0, 9'b111_01_0011, 8'd0, 8'd0, 1'b1, 4'h3, 12'h123);
        chk("t3_wr_old", next_pc, 12'h0A0);
        tick();
        step(0, 9'b111_01_0011, 0, 0); chk("t3_wr_new", next_pc, 12'h123); tick();

        // CMP giving GT immediately followed by BRR GT with flags previously EQ.
        step(0, 9'b110_000000, 8'd9, 8'd3);
        chk("t4_cmp_eq", EQ, 1'b1);
        chk("t4_cmp_gt", GT, 1'b0);
        chk("t4_cmp_cond", cond_sel, 2'b00);
        tick();
        step(0, 9'b101_11_0001, 0, 0);
        chk("t4_brr_gt", GT, 1'b1);
        chk("t4_brr_eq", EQ, 1'b0);
        chk("t4_brr_cond", cond_sel, 2'b11);
        tick();

        // HALT, then a restart.
        step(0, HALT, 0, 0); chk("t5_halt_hold", pc_hold, 1'b1); chk("t5_halt_done", done, 1'b0); tick();
        step(0, NOP, 0, 0); chk("t5_done", done, 1'b1); chk("t5_rc", run_cycles, 16'd13); tick();
        step(1, NOP, 0, 0); chk("t5_rc_frozen", run_cycles, 16'd13); chk("t5_done_hold", pc_hold, 1'b1); tick();
        step(1, NOP, 0, 0); chk("t5_done_clr", done, 1'b0); chk("t5_armed_hold", pc_hold, 1'b1); tick();
        step(0, NOP, 0, 0); chk("t5_resume_step", pc_hold, 1'b0); tick();
        step(0, NOP, 0, 0); chk("t5_rerun_rc", run_cycles, 16'd0); tick();

        // Reset in the middle of a run with GT set.
        step(0, 9'b110_000000, 8'd200, 8'd3); tick();
        step(0, NOP, 0, 0); chk("t6_gt", GT, 1'b1); tick();
        apply(1'b1, 1'b0, NOP, 8'd0, 8'd0, 1'b0, 4'h0, 12'h000); tick();
        step(0, 9'b111_01_0011, 0, 0);
        chk("t6_idle_hold", pc_hold, 1'b1);
        chk("t6_flags", {EQ, LT, GT}, 3'b000);
        chk("t6_done", done, 1'b0);
        chk("t6_lut3", next_pc, 12'h000);
        chk("t6_abs_en", abs_branch_en, 1'b0);
        tick();

        // Randomized programs with occasional mid-run resets and table writes.
        start_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            if (m_running) begin
                st = ($urandom % 8 == 0);
            end else if (start_cnt > 0) begin
                st = 1'b1;
                start_cnt--;
            end else begin
                st = 1'b0;
                if ($urandom % 4 == 0) start_cnt = $urandom_range(1, 3);
            end
            case ($urandom % 16)
                0, 1, 2, 3:     ins = {3'b101, 6'($urandom)};
                4, 5, 6, 7:     ins = {3'b111, 6'($urandom)};
                8, 9, 10, 11:   ins = {3'b110, 6'($urandom)};
                12:             ins = ($urandom % 3 == 0) ? HALT : 9'($urandom);
                default:        ins = 9'($urandom);
            endcase
            a   = ($urandom % 2 == 0) ? 8'($urandom % 8) : 8'($urandom);
            b   = ($urandom % 2 == 0) ? 8'($urandom % 8) : 8'($urandom);
            we  = ($urandom % 4 == 0);
            rst = ($urandom % 300 == 0);
            apply(rst, st, ins, a, b, we, 4'($urandom), 12'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
